// File: rtl/hazard_tnew_tracker.sv
// ---------------------------------------------------------------------------
// hazard_tnew_tracker
//
// Producer side of the forwarding-control interface. Each instruction's
// destination register (A3) and remaining result latency (Tnew) travel down
// EX/MEM/WB. Instructions in ID compare their read addresses and use
// deadlines (Tuse) against the EX and MEM producers. A stall is raised when
// forwarding cannot deliver the value in time.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   hold                 external freeze; all tracker state holds, stall = 0
//   flush_ex             kill the instruction entering EX (bubble)
//   A1_ID, A2_ID         rs/rt read addresses of the instruction in ID
//   Tuse_rs, Tuse_rt     cycles from ID until operand is needed (all-ones = not read)
//   A3_ID, Tnew_ID       destination and result latency of the instruction in ID
//   A3_EX/MEM/WB         destination tracked per stage
//   Tnew_EX/MEM/WB       remaining latency tracked per stage
//   stall                freeze PC and IF_ID, bubble into ID_EX
//   stall_cnt            saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_tnew_tracker #(
  parameter int TW    = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush_ex,
  input  logic [4:0]       A1_ID,
  input  logic [4:0]       A2_ID,
  input  logic [TW-1:0]    Tuse_rs,
  input  logic [TW-1:0]    Tuse_rt,
  input  logic [4:0]       A3_ID,
  input  logic [TW-1:0]    Tnew_ID,
  output logic [4:0]       A3_EX,
  output logic [4:0]       A3_MEM,
  output logic [4:0]       A3_WB,
  output logic [TW-1:0]    Tnew_EX,
  output logic [TW-1:0]    Tnew_MEM,
  output logic [TW-1:0]    Tnew_WB,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // A Tuse of all-ones means the operand is not read at all.
  localparam logic [TW-1:0] TUSE_NONE = '1;

  // Latency counts down by one per stage but never wraps below zero.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - TW'(1);
  endfunction

  // Youngest producer wins: an EX match shadows any MEM match for the same
  // register, since EX holds the most recent write to it.
  function automatic logic operand_hazard(
    input logic [4:0]    addr,
    input logic [TW-1:0] tuse,
    input logic [4:0]    a3_ex,
    input logic [TW-1:0] tnew_ex,
    input logic [4:0]    a3_mem,
    input logic [TW-1:0] tnew_mem
  );
    logic hit;
    hit = 1'b0;
    if (addr != 5'd0 && tuse != TUSE_NONE) begin
      if (addr == a3_ex)       hit = (tnew_ex > tuse);
      else if (addr == a3_mem) hit = (tnew_mem > tuse);
    end
    return hit;
  endfunction

  logic rs_hazard;
  logic rt_hazard;

  // NOTE: every always_comb output gets a default before any condition so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    rs_hazard = operand_hazard(A1_ID, Tuse_rs, A3_EX, Tnew_EX, A3_MEM, Tnew_MEM);
    rt_hazard = operand_hazard(A2_ID, Tuse_rt, A3_EX, Tnew_EX, A3_MEM, Tnew_MEM);
  end

  // WB is never consulted: its value is always available through the
  // register file or the final forwarding path.
  assign stall = (rs_hazard || rt_hazard) && !hold;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of the stage before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A3_EX     <= '0;
      A3_MEM    <= '0;
      A3_WB     <= '0;
      Tnew_EX   <= '0;
      Tnew_MEM  <= '0;
      Tnew_WB   <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      // Stall and flush both inject a bubble; asserting both still yields one.
      if (stall || flush_ex) begin
        A3_EX   <= '0;
        Tnew_EX <= '0;
      end else begin
        A3_EX   <= A3_ID;
        Tnew_EX <= Tnew_ID;
      end
      A3_MEM   <= A3_EX;
      Tnew_MEM <= sat_dec(Tnew_EX);
      A3_WB    <= A3_MEM;
      Tnew_WB  <= sat_dec(Tnew_MEM);
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
